// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Opcode/funct, ALU op, FSM state and exception cause encodings.
// Revision : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_slt = 6'b101010;

    localparam logic [2:0] c_alu_and = 3'd0;
    localparam logic [2:0] c_alu_or  = 3'd1;
    localparam logic [2:0] c_alu_add = 3'd2;
    localparam logic [2:0] c_alu_sub = 3'd6;
    localparam logic [2:0] c_alu_slt = 3'd7;

    localparam logic [3:0] c_st_rst    = 4'd0;
    localparam logic [3:0] c_st_fetch  = 4'd1;
    localparam logic [3:0] c_st_decode = 4'd2;
    localparam logic [3:0] c_st_memadr = 4'd3;
    localparam logic [3:0] c_st_memrd  = 4'd4;
    localparam logic [3:0] c_st_memwb  = 4'd5;
    localparam logic [3:0] c_st_memwr  = 4'd6;
    localparam logic [3:0] c_st_rex    = 4'd7;
    localparam logic [3:0] c_st_rwb    = 4'd8;
    localparam logic [3:0] c_st_beq    = 4'd9;
    localparam logic [3:0] c_st_aex    = 4'd10;
    localparam logic [3:0] c_st_awb    = 4'd11;
    localparam logic [3:0] c_st_jmp    = 4'd12;
    localparam logic [3:0] c_st_exc    = 4'd13;

    localparam logic [1:0] c_cause_none = 2'd0;
    localparam logic [1:0] c_cause_ovf  = 2'd1;
    localparam logic [1:0] c_cause_ill  = 2'd2;

    localparam logic [1:0] c_srcb_regb   = 2'd0;
    localparam logic [1:0] c_srcb_four   = 2'd1;
    localparam logic [1:0] c_srcb_imm    = 2'd2;
    localparam logic [1:0] c_srcb_imm_sh = 2'd3;

    localparam logic [1:0] c_pc_alu    = 2'd0;
    localparam logic [1:0] c_pc_aluout = 2'd1;
    localparam logic [1:0] c_pc_jump   = 2'd2;
    localparam logic [1:0] c_pc_exc    = 2'd3;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       exc_valid;
    } ctrl_t;

    // Only ADD and SUB produce a meaningful Ov flag.
    function automatic logic is_addsub(input logic [2:0] op);
        return (op == c_alu_add) || (op == c_alu_sub);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Brief    : R-type funct to ALU op, flagging unsupported funct codes.
// Revision : 1.0
// ============================================================================
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_op,
    output logic       o_illegal
);

    always_comb begin
        o_alu_op  = c_alu_add;
        o_illegal = 1'b0;
        case (i_funct)
            c_fn_add: o_alu_op = c_alu_add;
            c_fn_sub: o_alu_op = c_alu_sub;
            c_fn_and: o_alu_op = c_alu_and;
            c_fn_or:  o_alu_op = c_alu_or;
            c_fn_slt: o_alu_op = c_alu_slt;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Multicycle MIPS control FSM with overflow and illegal-op traps.
// Revision : 1.0
// ============================================================================
module multicycle_control
    import mips_pkg::*;
#(
    parameter bit TRAP_OVF = 1'b1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       ov,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       exc_valid,
    output logic [1:0] exc_cause
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [1:0] r_exc_cause;
    logic [1:0] w_cause_next;
    logic [2:0] w_rex_op;
    logic       w_rex_illegal;
    ctrl_t      w_ctrl;

    alu_decoder u_alu_decoder (
        .i_funct   (funct),
        .o_alu_op  (w_rex_op),
        .o_illegal (w_rex_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_rst;
            r_exc_cause <= c_cause_none;
        end else begin
            r_state <= w_next;
            if (w_next == c_st_exc) begin
                r_exc_cause <= w_cause_next;
            end
        end
    end

    always_comb begin
        w_next       = c_st_rst;
        w_cause_next = c_cause_none;
        case (r_state)
            c_st_rst:    w_next = c_st_fetch;
            c_st_fetch:  w_next = mem_ready ? c_st_decode : c_st_fetch;
            c_st_decode: begin
                case (opcode)
                    c_op_lw,
                    c_op_sw:    w_next = c_st_memadr;
                    c_op_rtype: w_next = c_st_rex;
                    c_op_beq:   w_next = c_st_beq;
                    c_op_addi:  w_next = c_st_aex;
                    c_op_j:     w_next = c_st_jmp;
                    default: begin
                        w_next       = c_st_exc;
                        w_cause_next = c_cause_ill;
                    end
                endcase
            end
            c_st_memadr: w_next = (opcode == c_op_lw) ? c_st_memrd : c_st_memwr;
            c_st_memrd:  w_next = mem_ready ? c_st_memwb : c_st_memrd;
            c_st_memwb:  w_next = c_st_fetch;
            c_st_memwr:  w_next = mem_ready ? c_st_fetch : c_st_memwr;
            c_st_rex: begin
                // An unknown funct outranks any overflow on the same cycle.
                if (w_rex_illegal) begin
                    w_next       = c_st_exc;
                    w_cause_next = c_cause_ill;
                end else if (TRAP_OVF && ov && is_addsub(w_rex_op)) begin
                    w_next       = c_st_exc;
                    w_cause_next = c_cause_ovf;
                end else begin
                    w_next = c_st_rwb;
                end
            end
            c_st_aex: begin
                if (TRAP_OVF && ov) begin
                    w_next       = c_st_exc;
                    w_cause_next = c_cause_ovf;
                end else begin
                    w_next = c_st_awb;
                end
            end
            c_st_rwb,
            c_st_beq,
            c_st_awb,
            c_st_jmp,
            c_st_exc:    w_next = c_st_fetch;
            default:     w_next = c_st_rst;
        endcase
    end

    always_comb begin
        w_ctrl        = '0;
        w_ctrl.alu_op = c_alu_add;
        case (r_state)
            c_st_rst:    w_ctrl = '0;
            c_st_fetch: begin
                w_ctrl.alu_src_b = c_srcb_four;
                w_ctrl.ir_write  = mem_ready;
                w_ctrl.pc_write  = mem_ready;
            end
            c_st_decode: w_ctrl.alu_src_b = c_srcb_imm_sh;
            c_st_memadr: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_srcb_imm;
            end
            c_st_memrd:  w_ctrl.iord = 1'b1;
            c_st_memwb: begin
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            c_st_memwr: begin
                w_ctrl.iord      = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            c_st_rex: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_srcb_regb;
                w_ctrl.alu_op    = w_rex_op;
            end
            c_st_rwb: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            c_st_beq: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_op    = c_alu_sub;
                w_ctrl.pc_src    = c_pc_aluout;
                w_ctrl.branch    = 1'b1;
            end
            c_st_aex: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_srcb_imm;
            end
            c_st_awb:    w_ctrl.reg_write = 1'b1;
            c_st_jmp: begin
                w_ctrl.pc_src   = c_pc_jump;
                w_ctrl.pc_write = 1'b1;
            end
            c_st_exc: begin
                w_ctrl.pc_src    = c_pc_exc;
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.exc_valid = 1'b1;
            end
            default:     w_ctrl = '0;
        endcase
    end

    // Write strobes are also gated by reset so they drop the instant it rises.
    assign alu_op     = w_ctrl.alu_op;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign iord       = w_ctrl.iord;
    assign mem_write  = w_ctrl.mem_write & ~reset;
    assign ir_write   = w_ctrl.ir_write & ~reset;
    assign reg_dst    = w_ctrl.reg_dst;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign reg_write  = w_ctrl.reg_write & ~reset;
    assign pc_src     = w_ctrl.pc_src;
    assign pc_en      = (w_ctrl.pc_write | (w_ctrl.branch & zero)) & ~reset;
    assign exc_valid  = w_ctrl.exc_valid;
    assign exc_cause  = r_exc_cause;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Randomized instruction-level checking of the multicycle control FSM.
// Revision : 1.0
// ============================================================================
module tb_multicycle_control;

    localparam logic [2:0] c_and = 3'd0;
    localparam logic [2:0] c_or  = 3'd1;
    localparam logic [2:0] c_add = 3'd2;
    localparam logic [2:0] c_sub = 3'd6;
    localparam logic [2:0] c_slt = 3'd7;

    typedef struct packed {
        logic [2:0] op;
        logic       a;
        logic [1:0] b;
        logic       iord;
        logic       mw;
        logic       irw;
        logic       rd;
        logic       m2r;
        logic       rw;
        logic [1:0] pcs;
        logic       pcen;
        logic       excv;
        logic [1:0] cause;
    } vec_t;

    typedef struct {
        logic       mr;
        logic       z;
        logic       o;
        logic [5:0] opc;
        logic [5:0] fn;
        vec_t       e;
        string      nm;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       ov = 1'b0;
    logic       mem_ready = 1'b0;

    logic [2:0] alu_op1, alu_op0;
    logic       src_a1, src_a0;
    logic [1:0] src_b1, src_b0;
    logic       iord1, iord0, mw1, mw0, irw1, irw0, rd1, rd0;
    logic       m2r1, m2r0, rw1, rw0, pcen1, pcen0, excv1, excv0;
    logic [1:0] pcs1, pcs0, cause1, cause0;

    step_t      plan[$];
    vec_t       got1[$];
    vec_t       got0[$];
    logic [1:0] m_cause;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    multicycle_control #(.TRAP_OVF(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .ov(ov),
        .mem_ready(mem_ready), .alu_op(alu_op1), .alu_src_a(src_a1), .alu_src_b(src_b1),
        .iord(iord1), .mem_write(mw1), .ir_write(irw1), .reg_dst(rd1), .mem_to_reg(m2r1),
        .reg_write(rw1), .pc_src(pcs1), .pc_en(pcen1), .exc_valid(excv1), .exc_cause(cause1)
    );

    multicycle_control #(.TRAP_OVF(1'b0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .ov(ov),
        .mem_ready(mem_ready), .alu_op(alu_op0), .alu_src_a(src_a0), .alu_src_b(src_b0),
        .iord(iord0), .mem_write(mw0), .ir_write(irw0), .reg_dst(rd0), .mem_to_reg(m2r0),
        .reg_write(rw0), .pc_src(pcs0), .pc_en(pcen0), .exc_valid(excv0), .exc_cause(cause0)
    );

    function automatic vec_t obs1();
        return '{alu_op1, src_a1, src_b1, iord1, mw1, irw1, rd1, m2r1, rw1, pcs1, pcen1, excv1, cause1};
    endfunction

    function automatic vec_t obs0();
        return '{alu_op0, src_a0, src_b0, iord0, mw0, irw0, rd0, m2r0, rw0, pcs0, pcen0, excv0, cause0};
    endfunction

    function automatic vec_t v(input logic [2:0] op, input logic a, input logic [1:0] b,
                               input logic iord, input logic mw, input logic irw, input logic rd,
                               input logic m2r, input logic rw, input logic [1:0] pcs,
                               input logic pcen, input logic excv);
        return '{op, a, b, iord, mw, irw, rd, m2r, rw, pcs, pcen, excv, m_cause};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic mr, input logic z, input logic o, input logic [5:0] opc,
                                 input logic [5:0] fn, input vec_t e, input string nm);
        step_t s;
        s.mr = mr; s.z = z; s.o = o; s.opc = opc; s.fn = fn; s.e = e; s.nm = nm;
        plan.push_back(s);
    endfunction

    // sel: 0/1 forces the flag, 2 randomizes it
    function automatic logic pick(input int sel);
        return (sel == 2) ? rb() : sel[0];
    endfunction

    function automatic int waits(input int mrw);
        return (mrw < 0) ? int'($urandom_range(0, 3)) : mrw;
    endfunction

    function automatic void add_exc(input logic [5:0] opc, input logic [5:0] fn, input logic [1:0] c);
        m_cause = c;
        push(rb(), rb(), rb(), opc, fn, v(c_add, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd3, 1, 1), "EXC");
    endfunction

    // Instruction-level reference: the expected per-cycle control pattern of one instruction.
    function automatic void add_instr(input logic [5:0] opc, input logic [5:0] fn, input int zsel,
                                      input int osel, input int mrw, input bit trap);
        int         w;
        logic       mr;
        logic       o;
        logic       z;
        logic [2:0] op;
        bit         legal;
        w = waits(mrw);
        for (int k = 0; k <= w; k++) begin
            mr = (k == w);
            push(mr, rb(), rb(), opc, fn, v(c_add, 0, 2'd1, 0, 0, mr, 0, 0, 0, 2'd0, mr, 0), "FETCH");
        end
        push(rb(), rb(), rb(), opc, fn, v(c_add, 0, 2'd3, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0), "DECODE");
        case (opc)
            6'b100011, 6'b101011: begin
                push(rb(), rb(), rb(), opc, fn, v(c_add, 1, 2'd2, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0), "MEMADR");
                w = waits(mrw);
                for (int k = 0; k <= w; k++) begin
                    mr = (k == w);
                    if (opc == 6'b100011)
                        push(mr, rb(), rb(), opc, fn, v(c_add, 0, 2'd0, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0), "MEMRD");
                    else
                        push(mr, rb(), rb(), opc, fn, v(c_add, 0, 2'd0, 1, 1, 0, 0, 0, 0, 2'd0, 0, 0), "MEMWR");
                end
                if (opc == 6'b100011)
                    push(rb(), rb(), rb(), opc, fn, v(c_add, 0, 2'd0, 0, 0, 0, 0, 1, 1, 2'd0, 0, 0), "MEMWB");
            end
            6'b000000: begin
                legal = 1'b1;
                op    = c_add;
                case (fn)
                    6'b100000: op = c_add;
                    6'b100010: op = c_sub;
                    6'b100100: op = c_and;
                    6'b100101: op = c_or;
                    6'b101010: op = c_slt;
                    default:   legal = 1'b0;
                endcase
                o = pick(osel);
                push(rb(), rb(), o, opc, fn, v(op, 1, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0), "REX");
                if (!legal)
                    add_exc(opc, fn, 2'd2);
                else if (trap && o && (op == c_add || op == c_sub))
                    add_exc(opc, fn, 2'd1);
                else
                    push(rb(), rb(), rb(), opc, fn, v(c_add, 0, 2'd0, 0, 0, 0, 1, 0, 1, 2'd0, 0, 0), "RWB");
            end
            6'b000100: begin
                z = pick(zsel);
                push(rb(), z, rb(), opc, fn, v(c_sub, 1, 2'd0, 0, 0, 0, 0, 0, 0, 2'd1, z, 0), "BEQ");
            end
            6'b001000: begin
                o = pick(osel);
                push(rb(), rb(), o, opc, fn, v(c_add, 1, 2'd2, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0), "AEX");
                if (trap && o)
                    add_exc(opc, fn, 2'd1);
                else
                    push(rb(), rb(), rb(), opc, fn, v(c_add, 0, 2'd0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0), "AWB");
            end
            6'b000010:
                push(rb(), rb(), rb(), opc, fn, v(c_add, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd2, 1, 0), "JMP");
            default:
                add_exc(opc, fn, 2'd2);
        endcase
    endfunction

    // Reset both DUTs and leave the bench one cycle before the first FETCH.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        m_cause = 2'd0;
        plan.delete();
        push(rb(), rb(), rb(), 6'($urandom), 6'($urandom), '0, "RST");
    endtask

    task automatic drive_plan();
        got1.delete();
        got0.delete();
        foreach (plan[i]) begin
            @(negedge clk);
            mem_ready = plan[i].mr;
            zero      = plan[i].z;
            ov        = plan[i].o;
            opcode    = plan[i].opc;
            funct     = plan[i].fn;
            #1;
            got1.push_back(obs1());
            got0.push_back(obs0());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs1() !== vec_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", obs1());
        end
        checks++;
        if (obs0() !== vec_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs_notrap: got %h expected 0", obs0());
        end
    endtask

    task automatic test_lw();
        int n;
        do_reset();
        add_instr(6'b100011, 6'($urandom), 2, 2, 0, 1'b1);
        drive_plan();
        n = 0;
        foreach (plan[i]) begin
            checks++;
            if (got1[i] !== plan[i].e) begin
                errors++;
                $display("FAIL lw[%0d] %s: got %h expected %h", i, plan[i].nm, got1[i], plan[i].e);
            end
            if (got1[i].rw && got1[i].m2r) n++;
        end
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL lw_memwb_count: got %0d expected 1", n);
        end
    endtask

    task automatic test_fetch_stall();
        int n;
        do_reset();
        add_instr(6'b000010, 6'($urandom), 2, 2, 3, 1'b1);
        drive_plan();
        n = 0;
        foreach (plan[i]) begin
            checks++;
            if (got1[i] !== plan[i].e) begin
                errors++;
                $display("FAIL stall[%0d] %s: got %h expected %h", i, plan[i].nm, got1[i], plan[i].e);
            end
            if (got1[i].irw === 1'b1) n++;
        end
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL stall_irwrite_pulses: got %0d expected 1", n);
        end
    endtask

    task automatic test_beq();
        int n;
        do_reset();
        add_instr(6'b000100, 6'($urandom), 1, 2, 0, 1'b1);
        add_instr(6'b000100, 6'($urandom), 0, 2, 1, 1'b1);
        add_instr(6'b000100, 6'($urandom), 1, 2, 0, 1'b1);
        drive_plan();
        n = 0;
        foreach (plan[i]) begin
            checks++;
            if (got1[i] !== plan[i].e) begin
                errors++;
                $display("FAIL beq[%0d] %s: got %h expected %h", i, plan[i].nm, got1[i], plan[i].e);
            end
            if (got1[i].pcen === 1'b1 && got1[i].pcs === 2'd1) n++;
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL beq_taken_count: got %0d expected 2", n);
        end
    endtask

    task automatic test_ov_trap();
        int n;
        do_reset();
        add_instr(6'b000000, 6'b100000, 2, 1, 0, 1'b1);
        add_instr(6'b000000, 6'b100010, 2, 1, 1, 1'b1);
        add_instr(6'b001000, 6'($urandom), 2, 1, 0, 1'b1);
        add_instr(6'b001000, 6'($urandom), 2, 0, 0, 1'b1);
        drive_plan();
        n = 0;
        foreach (plan[i]) begin
            checks++;
            if (got1[i] !== plan[i].e) begin
                errors++;
                $display("FAIL ovtrap[%0d] %s: got %h expected %h", i, plan[i].nm, got1[i], plan[i].e);
            end
            if (got1[i].excv === 1'b1) n++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL ovtrap_exc_pulses: got %0d expected 3", n);
        end
    endtask

    task automatic test_no_trap();
        do_reset();
        add_instr(6'b000000, 6'b100000, 2, 1, 0, 1'b0);
        add_instr(6'b001000, 6'($urandom), 2, 1, 0, 1'b0);
        add_instr(6'b000000, 6'b100010, 2, 1, 0, 1'b0);
        drive_plan();
        foreach (plan[i]) begin
            checks++;
            if (got0[i] !== plan[i].e) begin
                errors++;
                $display("FAIL notrap[%0d] %s: got %h expected %h", i, plan[i].nm, got0[i], plan[i].e);
            end
        end
    endtask

    task automatic test_slt_illegal();
        do_reset();
        add_instr(6'b000000, 6'b101010, 2, 1, 0, 1'b1);
        add_instr(6'b111111, 6'($urandom), 2, 2, 0, 1'b1);
        add_instr(6'b000000, 6'b100100, 2, 1, 0, 1'b1);
        add_instr(6'b000000, 6'b100101, 2, 1, 0, 1'b1);
        add_instr(6'b000000, 6'b000001, 2, 1, 0, 1'b1);
        add_instr(6'b000010, 6'($urandom), 2, 2, 0, 1'b1);
        drive_plan();
        foreach (plan[i]) begin
            checks++;
            if (got1[i] !== plan[i].e) begin
                errors++;
                $display("FAIL sltill[%0d] %s: got %h expected %h", i, plan[i].nm, got1[i], plan[i].e);
            end
        end
    endtask

    task automatic test_random_program();
        logic [5:0] ops[7];
        logic [5:0] fns[6];
        logic [5:0] opc;
        logic [5:0] fn;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        do_reset();
        for (int n = 0; n < 40; n++) begin
            opc = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) opc = 6'($urandom);
            fn = fns[$urandom_range(0, 5)];
            if (fn == 6'b000000) fn = 6'($urandom);
            add_instr(opc, fn, 2, 2, -1, 1'b1);
        end
        drive_plan();
        foreach (plan[i]) begin
            checks++;
            if (got1[i] !== plan[i].e) begin
                errors++;
                $display("FAIL random[%0d] %s: got %h expected %h", i, plan[i].nm, got1[i], plan[i].e);
            end
        end
    endtask

    task automatic test_reset_memwr();
        do_reset();
        add_instr(6'b111111, 6'($urandom), 2, 2, 0, 1'b1);
        add_instr(6'b101011, 6'($urandom), 2, 2, 6, 1'b1);
        // Stop two cycles into the stalled store.
        repeat (5) void'(plan.pop_back());
        drive_plan();
        foreach (plan[i]) begin
            checks++;
            if (got1[i] !== plan[i].e) begin
                errors++;
                $display("FAIL memwr[%0d] %s: got %h expected %h", i, plan[i].nm, got1[i], plan[i].e);
            end
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (mw1 !== 1'b0) begin
            errors++;
            $display("FAIL memwr_async_drop: got mem_write=%b expected 0", mw1);
        end
        checks++;
        if (obs1() !== vec_t'(0)) begin
            errors++;
            $display("FAIL memwr_reset_outputs: got %h expected 0", obs1());
        end
        do_reset();
        add_instr(6'b100011, 6'($urandom), 2, 2, -1, 1'b1);
        drive_plan();
        foreach (plan[i]) begin
            checks++;
            if (got1[i] !== plan[i].e) begin
                errors++;
                $display("FAIL resume[%0d] %s: got %h expected %h", i, plan[i].nm, got1[i], plan[i].e);
            end
        end
    endtask

    initial begin
        m_cause = 2'd0;
        test_reset();
        test_lw();
        test_fetch_stall();
        test_beq();
        test_ov_trap();
        test_no_trap();
        test_slt_illegal();
        test_random_program();
        test_reset_memwr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
